rom_burst_reader: RTL and testbench
===================================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ROM data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, ROM address width; also the width of the burst length.
REQ-003 CLK_I  input  1  single clock; all logic on rising edge.
REQ-004 RSTN_I  input  1  reset; synchronous, active-low.
REQ-005 START_I  input  1  one-cycle burst request; sampled only in IDLE.
REQ-006 BASE_ADDR_I  input  ADDR_WIDTH  first ROM address of the burst; captured with START_I.
REQ-007 LEN_I  input  ADDR_WIDTH  number of words to read; captured with START_I.
REQ-008 ROM_RE_O  output  1  read enable to the ROM.
REQ-009 ROM_ADDR_O  output  ADDR_WIDTH  read address to the ROM.
REQ-010 ROM_DATA_I  input  DATA_WIDTH  ROM read data; valid exactly 1 cycle after a cycle with ROM_RE_O=1.
REQ-011 ROM_ADDR_I  input  ADDR_WIDTH  ROM address echo; arrives with ROM_DATA_I.
REQ-012 DATA_O  output  DATA_WIDTH  stream data word.
REQ-013 VALID_O  output  1  DATA_O holds a valid word.
REQ-014 READY_I  input  1  consumer accepts the word; a transfer occurs on a cycle with VALID_O=1 and READY_I=1.
REQ-015 BUSY_O  output  1  high in any state other than IDLE.
REQ-016 DONE_O  output  1  one-cycle pulse when the burst completes.
REQ-017 ERR_O  output  1  sticky flag: an address echo mismatch has occurred.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
- IDLE->RUN: on START_I=1 with LEN_I!=0.
- IDLE->DONE: on START_I=1 with LEN_I=0; no ROM read is issued.
- RUN->DRAIN: in the cycle after the last read is issued.
- DRAIN->DONE: when the buffer is empty, no read is in flight and no transfer is pending.
- DONE->IDLE: always, after one cycle.
REQ-019 The block SHALL issue reads in RUN only.
- Condition: buffer occupancy + in-flight reads < 2.
- Cap: at most one read per cycle.
- ROM_RE_O=1 only on issue cycles; ROM_ADDR_O holds the issued address.
REQ-020 Addresses SHALL be BASE_ADDR_I, BASE_ADDR_I+1, and so on, modulo 2^ADDR_WIDTH.
- Example: base 8'hFE, length 3 -> FE, FF, 00.
REQ-021 Returned words SHALL enter a 2-entry FIFO; DATA_O/VALID_O SHALL present the FIFO head.
- Full throughput: one word per cycle when READY_I is held at 1.
REQ-022 Backpressure: while VALID_O=1 and READY_I=0, DATA_O SHALL hold stable.
- No word is lost, duplicated or reordered.
REQ-023 The FIFO SHALL never overflow; REQ-019 guarantees this by construction.
REQ-024 Latency: with READY_I=1, the first word SHALL appear on VALID_O 2 cycles after the START_I cycle.
- Cycle +1: RUN, issue. Cycle +2: data registered.
REQ-025 Echo check: each returned ROM_ADDR_I is compared to its issued address; any mismatch SHALL set ERR_O.
- ERR_O clears only on reset or on the next accepted START_I.
REQ-026 DONE_O SHALL be 1 only in the DONE state.
- It occurs exactly after all LEN_I words have been transferred.
REQ-027 START_I outside IDLE SHALL be ignored.
REQ-028 Internal counters SHALL be ADDR_WIDTH+1 bits wide, so LEN_I=2^ADDR_WIDTH-1 completes without overflow.

Reset
REQ-029 On a rising edge with RSTN_I=0, the block SHALL return to IDLE.
- Outputs: ROM_RE_O=0, ROM_ADDR_O=0, DATA_O=0, VALID_O=0, BUSY_O=0, DONE_O=0, ERR_O=0.
- State: FIFO emptied, in-flight read discarded.
REQ-030 Reset mid-burst SHALL abort the burst; no DONE_O pulse is produced for the aborted burst.
REQ-031 After reset release, the first START_I SHALL be honoured on the first cycle with RSTN_I=1.

Verification
REQ-032 Basic burst: base=8'h10, LEN=4, READY_I=1, ROM data=addr -> DATA_O 10,11,12,13 on consecutive cycles, first at START+2; DONE_O one cycle after the last transfer.
REQ-033 Wrap: base=8'hFE, LEN=3 -> ROM_ADDR_O FE,FF,00; DATA_O FE,FF,00.
REQ-034 Backpressure: base=0, LEN=8, READY_I toggles 1,0,0,1,... -> all 8 words 00..07 delivered in order, DATA_O stable while stalled, never more than 2 reads outstanding plus buffered.
REQ-035 Zero length: LEN=0 -> no ROM_RE_O, DONE_O pulses at START+1, VALID_O stays 0.
REQ-036 Echo error: ROM model corrupts ROM_ADDR_I on the 2nd read -> ERR_O=1 from that return cycle onward; the burst still completes; the next START_I clears ERR_O.
REQ-037 Reset mid-burst: RSTN_I=0 for one cycle during word 3 of LEN=8 -> next cycle IDLE, all outputs 0, no DONE_O; a fresh START_I then runs normally.

Source files
------------

// File: rtl/rom_burst_reader.sv
// Burst reader: streams LEN_I consecutive ROM words starting at BASE_ADDR_I
// through a 2-entry FIFO with ready/valid handshake and address-echo checking.
module rom_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK_I,
  input  logic                  RSTN_I,
  input  logic                  START_I,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR_I,
  input  logic [ADDR_WIDTH-1:0] LEN_I,
  output logic                  ROM_RE_O,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR_O,
  input  logic [DATA_WIDTH-1:0] ROM_DATA_I,
  input  logic [ADDR_WIDTH-1:0] ROM_ADDR_I,
  output logic [DATA_WIDTH-1:0] DATA_O,
  output logic                  VALID_O,
  input  logic                  READY_I,
  output logic                  BUSY_O,
  output logic                  DONE_O,
  output logic                  ERR_O
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_issue_left;
  logic                  r_err;

  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_issue;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_mismatch;
  logic [1:0]            w_occ;
  logic [1:0]            w_count_nxt;

  assign w_accept    = (r_state == S_IDLE) && START_I;
  assign w_occ       = r_count + {1'b0, r_vld_p1};
  // A returning word bypasses the FIFO when it is empty and the consumer is ready.
  assign w_push      = r_vld_p1 && !((r_count == 2'd0) && READY_I);
  assign w_pop       = (r_count != 2'd0) && READY_I;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_mismatch  = r_vld_p1 && (ROM_ADDR_I != r_addr_p1);

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    BUSY_O      = (r_state != S_IDLE);
    DONE_O      = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (START_I) w_state_nxt = (LEN_I == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_issue = (r_issue_left != '0) && (w_occ < 2'd2);
        if (w_issue && (r_issue_left == {{ADDR_WIDTH{1'b0}}, 1'b1}))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_count_nxt == 2'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: issued read and its address, awaiting ROM return.
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      r_vld_p1     <= 1'b0;
      r_count      <= 2'd0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_err        <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      r_count  <= w_count_nxt;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      if (w_accept) begin
        r_addr       <= BASE_ADDR_I;
        r_issue_left <= {1'b0, LEN_I};
      end else if (w_issue) begin
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_issue_left <= r_issue_left - (ADDR_WIDTH+1)'(1);
      end
      if (w_accept)        r_err <= 1'b0;
      else if (w_mismatch) r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (w_push)  r_mem[r_wptr] <= ROM_DATA_I;
    if (w_issue) r_addr_p1     <= r_addr;
  end

  // Stage p1 -> output: FIFO head, or the live ROM word when the FIFO is empty.
  always_comb begin
    DATA_O = '0;
    if (r_count != 2'd0) DATA_O = r_mem[r_rptr];
    else if (r_vld_p1)   DATA_O = ROM_DATA_I;
  end

  assign VALID_O    = (r_count != 2'd0) || r_vld_p1;
  assign ROM_RE_O   = w_issue;
  assign ROM_ADDR_O = r_addr;
  assign ERR_O      = r_err || w_mismatch;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: ROM model, stream reference model
// derived from base/length arithmetic, directed and randomized bursts.
module tb_rom_burst_reader;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len = '0;
  logic          rom_re;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] rom_echo;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready = 1'b1;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  rom_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK_I(clk), .RSTN_I(rstn), .START_I(start), .BASE_ADDR_I(base_addr),
    .LEN_I(len), .ROM_RE_O(rom_re), .ROM_ADDR_O(rom_addr), .ROM_DATA_I(rom_data),
    .ROM_ADDR_I(rom_echo), .DATA_O(data), .VALID_O(valid), .READY_I(ready),
    .BUSY_O(busy), .DONE_O(done), .ERR_O(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rom_tab [256];
  bit          rom_rand  = 1'b0;
  int          corrupt_n = -1;
  int          rd_idx    = 0;

  function automatic logic [7:0] romv(input logic [7:0] a);
    return rom_rand ? rom_tab[a] : a;
  endfunction

  function automatic logic [7:0] exp_word(input logic [7:0] b, input int i);
    logic [7:0] a;
    a = b + 8'(i);
    return romv(a);
  endfunction

  // ROM: one-cycle read latency, garbage on the bus when not read.
  always @(posedge clk) begin
    if (rom_re) begin
      rom_data <= romv(rom_addr);
      rom_echo <= (rd_idx == corrupt_n) ? (rom_addr ^ 8'h5A) : rom_addr;
    end else begin
      rom_data <= 8'($urandom);
      rom_echo <= 8'($urandom);
    end
    if (start && !busy) rd_idx <= 0;
    else if (rom_re)    rd_idx <= rd_idx + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] got_q [$];
  logic [7:0] addr_q [$];
  int         xfer_cyc_q [$];
  int first_valid, done_cyc, done_cnt, re_cnt, stall_viol, max_out, err_cyc, issued, xfered;
  logic err_c1, err_end;
  logic [7:0] pr_addr, pr_data;
  logic pr_re, pr_valid, pr_busy, pr_done, pr_err;

  function automatic logic rdy_of(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic run_burst(input logic [7:0] b, input logic [7:0] l, input int mode,
                           input int reset_at, input int spur_at);
    int budget;
    bit prev_stall;
    logic [7:0] prev_data;
    got_q.delete(); addr_q.delete(); xfer_cyc_q.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; re_cnt = 0; stall_viol = 0;
    max_out = 0; err_cyc = -1; issued = 0; xfered = 0; err_c1 = 1'b0; err_end = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    budget = (mode == 0) ? int'(l) + 10 : 8 * int'(l) + 40;
    if (reset_at >= 0) budget = reset_at + 4;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == 0) || (cyc == spur_at);
      base_addr = (cyc == spur_at) ? ~b : b;
      len       = (cyc == spur_at) ? 8'd5 : l;
      ready     = rdy_of(mode, cyc);
      rstn      = (cyc != reset_at);
      @(negedge clk);
      if (rom_re) begin addr_q.push_back(rom_addr); re_cnt++; issued++; end
      if (issued - xfered > max_out) max_out = issued - xfered;
      if (prev_stall && (!valid || data !== prev_data)) stall_viol++;
      if (valid && first_valid < 0) first_valid = cyc;
      if (valid && ready) begin got_q.push_back(data); xfer_cyc_q.push_back(cyc); xfered++; end
      prev_stall = valid && !ready;
      prev_data  = data;
      if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (cyc == 1) err_c1 = err;
      if (reset_at >= 0 && cyc == reset_at + 1) begin
        pr_re = rom_re; pr_addr = rom_addr; pr_data = data; pr_valid = valid;
        pr_busy = busy; pr_done = done; pr_err = err;
      end
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc; err_end = err;
        if (reset_at < 0) break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1; rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (rom_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", rom_re); end
    n_tests++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
    n_tests++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk); #1;
    rstn = 1'b1; start = 1'b1; base_addr = 8'h03; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_after_reset_busy: got %b want 1", busy); end
    n_tests++; if (rom_re !== 1'b1 || rom_addr !== 8'h03)
      begin n_fail++; $display("FAIL start_after_reset_read: got re=%b addr=%h want re=1 addr=03", rom_re, rom_addr); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic;
    rom_rand = 1'b0; corrupt_n = -1;
    run_burst(8'h10, 8'd4, 0, -1, -1);
    n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_q[i] !== exp_word(8'h10, i))
        begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp_word(8'h10, i)); end
    end
    n_tests++; if (first_valid != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", first_valid); end
    n_tests++; if (xfer_cyc_q.size() != 4 || xfer_cyc_q[3] - xfer_cyc_q[0] != 3)
      begin n_fail++; $display("FAIL basic_consecutive: got %0d transfers, not back-to-back", xfer_cyc_q.size()); end
    n_tests++; if (done_cnt != 1 || xfer_cyc_q.size() == 0 || done_cyc != xfer_cyc_q[$] + 1)
      begin n_fail++; $display("FAIL basic_done: got count=%0d cycle=%0d want count=1 cycle after last transfer", done_cnt, done_cyc); end
    n_tests++; if (re_cnt != 4) begin n_fail++; $display("FAIL basic_reads: got %0d want 4", re_cnt); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_a [3];
    exp_a = '{8'hFE, 8'hFF, 8'h00};
    rom_rand = 1'b0;
    run_burst(8'hFE, 8'd3, 0, -1, -1);
    n_tests++; if (addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_reads: got %0d want 3", addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (addr_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_q[i], exp_a[i]); end
      n_tests++; if (got_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", i, got_q[i], exp_a[i]); end
    end
  endtask

  task automatic test_backpressure;
    rom_rand = 1'b0;
    run_burst(8'h00, 8'd8, 1, -1, -1);
    n_tests++; if (got_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (got_q[i] !== 8'(i)) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], 8'(i)); end
    end
    n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol); end
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_len;
    run_burst(8'h33, 8'd0, 0, -1, -1);
    n_tests++; if (re_cnt != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", re_cnt); end
    n_tests++; if (done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    n_tests++; if (first_valid != -1) begin n_fail++; $display("FAIL zero_valid: valid seen at cycle %0d want never", first_valid); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_echo_err;
    rom_rand = 1'b0; corrupt_n = 1;
    run_burst(8'h20, 8'd4, 0, -1, -1);
    corrupt_n = -1;
    n_tests++; if (err_cyc != 3) begin n_fail++; $display("FAIL err_rise: got cycle %0d want 3", err_cyc); end
    n_tests++; if (err_end !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b at done want 1", err_end); end
    n_tests++; if (done_cnt != 1 || got_q.size() != 4)
      begin n_fail++; $display("FAIL err_complete: got done=%0d words=%0d want 1 and 4", done_cnt, got_q.size()); end
    @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_idle: got %b want 1", err); end
    run_burst(8'h24, 8'd2, 0, -1, -1);
    n_tests++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_c1); end
    n_tests++; if (err_end !== 1'b0) begin n_fail++; $display("FAIL err_clean_burst: got %b want 0", err_end); end
  endtask

  task automatic test_reset_mid;
    rom_rand = 1'b0;
    run_burst(8'h40, 8'd8, 0, 4, -1);
    n_tests++; if (pr_re !== 1'b0 || pr_addr !== 8'h00)
      begin n_fail++; $display("FAIL midrst_rom: got re=%b addr=%h want 0 00", pr_re, pr_addr); end
    n_tests++; if (pr_valid !== 1'b0 || pr_data !== 8'h00)
      begin n_fail++; $display("FAIL midrst_stream: got valid=%b data=%h want 0 00", pr_valid, pr_data); end
    n_tests++; if (pr_busy !== 1'b0 || pr_done !== 1'b0 || pr_err !== 1'b0)
      begin n_fail++; $display("FAIL midrst_flags: got busy=%b done=%b err=%b want 000", pr_busy, pr_done, pr_err); end
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d want 0", done_cnt); end
    run_burst(8'h50, 8'd3, 0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got_q[i] !== exp_word(8'h50, i))
        begin n_fail++; $display("FAIL midrst_fresh%0d: got %h want %h", i, got_q[i], exp_word(8'h50, i)); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL midrst_fresh_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored;
    rom_rand = 1'b1;
    run_burst(8'h60, 8'd6, 0, -1, 3);
    n_tests++; if (got_q.size() != 6 || re_cnt != 6)
      begin n_fail++; $display("FAIL spur_count: got words=%0d reads=%0d want 6 6", got_q.size(), re_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (got_q[i] !== exp_word(8'h60, i))
        begin n_fail++; $display("FAIL spur_word%0d: got %h want %h", i, got_q[i], exp_word(8'h60, i)); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL spur_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random;
    logic [7:0] b, l;
    int bad;
    rom_rand = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b = 8'($urandom);
      l = 8'($urandom_range(0, 40));
      run_burst(b, l, 2, -1, $urandom_range(1, 8));
      bad = 0;
      for (int i = 0; i < int'(l); i++) if (got_q[i] !== exp_word(b, i)) bad++;
      n_tests++; if (got_q.size() != int'(l))
        begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", k, got_q.size(), l); end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_words: got %0d wrong words want 0", k, bad); end
      n_tests++; if (stall_viol != 0 || max_out > 2)
        begin n_fail++; $display("FAIL rand%0d_flow: got stall_viol=%0d outstanding=%0d", k, stall_viol, max_out); end
      n_tests++; if (done_cnt != 1 || (l != 0 && (xfer_cyc_q.size() == 0 || done_cyc != xfer_cyc_q[$] + 1)))
        begin n_fail++; $display("FAIL rand%0d_done: got count=%0d cycle=%0d", k, done_cnt, done_cyc); end
      n_tests++; if (err_cyc != -1) begin n_fail++; $display("FAIL rand%0d_err: got err at cycle %0d want none", k, err_cyc); end
    end
  endtask

  task automatic test_long;
    int bad;
    rom_rand = 1'b1;
    run_burst(8'hC3, 8'd255, 0, -1, -1);
    bad = 0;
    for (int i = 0; i < 255; i++) if (got_q[i] !== exp_word(8'hC3, i)) bad++;
    n_tests++; if (got_q.size() != 255 || re_cnt != 255)
      begin n_fail++; $display("FAIL long_count: got words=%0d reads=%0d want 255", got_q.size(), re_cnt); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL long_words: got %0d wrong words want 0", bad); end
    n_tests++; if (done_cyc != 257) begin n_fail++; $display("FAIL long_done: got cycle %0d want 257", done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tab[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_echo_err();
    test_reset_mid();
    test_start_ignored();
    test_random();
    test_long();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
